// File: rtl/seq_signed_divider_if.sv
// Handshake/data bundle for seq_signed_divider.
//   start     : request, sampled only while the divider is idle
//   dividend  : 2*WIDTH-bit signed dividend, captured on accepted start
//   divisor   : WIDTH-bit signed divisor, captured on accepted start
//   busy      : high while a division is in progress
//   done      : one-cycle pulse when quotient/remainder/flags update
//   quotient  : 2*WIDTH-bit signed quotient, truncated toward zero
//   remainder : WIDTH-bit signed remainder, sign follows dividend
//   div_zero  : divisor was zero for the reported result
//   ovf       : quotient not representable (most-negative / -1)
interface seq_signed_divider_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   div_zero;
    logic                   ovf;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero, ovf
    );
endinterface

// File: rtl/seq_signed_divider.sv
// Multi-cycle signed restoring divider: 2*WIDTH-bit dividend by WIDTH-bit
// divisor, fixed latency of 2*WIDTH+1 cycles from accepted start to done.
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset; aborts any in-flight division
//   bus : seq_signed_divider_if slave (start/operands in, busy/done/results out)
module seq_signed_divider #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_signed_divider_if.slave  bus
);
    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(DW) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [DW-1:0]      dvd_q, dvd_d;       // |dividend|, quotient bits shift in at LSB
    logic [WIDTH-1:0]   rem_q, rem_d;       // partial remainder, always < |divisor|
    logic [WIDTH:0]     dsr_q, dsr_d;       // |divisor|, one extra bit for -2^(WIDTH-1)
    logic               dvd_neg_q, dvd_neg_d;
    logic               q_neg_q, q_neg_d;
    logic               dz_q, dz_d;
    logic               ovf_flag_q, ovf_flag_d;
    logic [WIDTH-1:0]   dvd_lo_q, dvd_lo_d; // remainder reported on divide by zero
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [DW-1:0]      quot_q, quot_d;
    logic [WIDTH-1:0]   remo_q, remo_d;
    logic               div_zero_q, div_zero_d;
    logic               ovf_q, ovf_d;

    logic [WIDTH:0]     shifted;
    logic               ge;
    logic signed [WIDTH:0] dsr_ext;

    assign shifted = {rem_q, dvd_q[DW-1]};
    assign ge      = (shifted >= dsr_q);
    assign dsr_ext = {bus.divisor[WIDTH-1], bus.divisor};

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; that is what keeps this block from inferring latches.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        rem_d      = rem_q;
        dsr_d      = dsr_q;
        dvd_neg_d  = dvd_neg_q;
        q_neg_d    = q_neg_q;
        dz_d       = dz_q;
        ovf_flag_d = ovf_flag_q;
        dvd_lo_d   = dvd_lo_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        quot_d     = quot_q;
        remo_d     = remo_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_neg_d  = bus.dividend[DW-1];
                    q_neg_d    = bus.dividend[DW-1] ^ bus.divisor[WIDTH-1];
                    // Negating the most-negative dividend yields 2^(DW-1), which
                    // is the correct unsigned magnitude.
                    dvd_d      = bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
                    dsr_d      = dsr_ext[WIDTH] ? unsigned'(-dsr_ext) : unsigned'(dsr_ext);
                    rem_d      = '0;
                    dz_d       = (bus.divisor == '0);
                    ovf_flag_d = (bus.dividend == {1'b1, {(DW-1){1'b0}}}) &&
                                 (bus.divisor == {WIDTH{1'b1}});
                    dvd_lo_d   = bus.dividend[WIDTH-1:0];
                    cnt_d      = CW'(DW);
                    busy_d     = 1'b1;
                    state_d    = CALC;
                end
            end
            CALC: begin
                // Restored value is < |divisor| <= 2^(WIDTH-1), so WIDTH bits hold it.
                rem_d = ge ? WIDTH'(shifted - dsr_q) : shifted[WIDTH-1:0];
                dvd_d = {dvd_q[DW-2:0], ge};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                if (dz_q) begin
                    quot_d = '1;
                    remo_d = dvd_lo_q;
                end else begin
                    quot_d = q_neg_q ? -dvd_q : dvd_q;
                    remo_d = dvd_neg_q ? -rem_q : rem_q;
                end
                div_zero_d = dz_q;
                ovf_d      = ovf_flag_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            rem_q      <= '0;
            dsr_q      <= '0;
            dvd_neg_q  <= 1'b0;
            q_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            ovf_flag_q <= 1'b0;
            dvd_lo_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quot_q     <= '0;
            remo_q     <= '0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            rem_q      <= rem_d;
            dsr_q      <= dsr_d;
            dvd_neg_q  <= dvd_neg_d;
            q_neg_q    <= q_neg_d;
            dz_q       <= dz_d;
            ovf_flag_q <= ovf_flag_d;
            dvd_lo_q   <= dvd_lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            quot_q     <= quot_d;
            remo_q     <= remo_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quot_q;
    assign bus.remainder = remo_q;
    assign bus.div_zero  = div_zero_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider (WIDTH=8): a behavioural
// reference built on plain integer division, a per-cycle compare process,
// directed sign/boundary/handshake/reset cases and a randomized run.
module tb_seq_signed_divider;
    localparam int WIDTH = 8;
    localparam int DW    = 2 * WIDTH;
    localparam int LAT   = DW + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmp_en = 1'b0;
    int   tests = 0;
    int   fails = 0;

    seq_signed_divider_if #(.WIDTH(WIDTH)) bus ();

    seq_signed_divider #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: truncating signed division from the language's own operators.
    function automatic void model(input logic [DW-1:0] dd, input logic [WIDTH-1:0] ds,
                                  output logic [DW-1:0] q, output logic [WIDTH-1:0] r,
                                  output logic dz, output logic ov);
        longint a, b, qq;
        a  = longint'($signed(dd));
        b  = longint'($signed(ds));
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            dz = 1'b1;
            q  = '1;
            r  = dd[WIDTH-1:0];
        end else begin
            qq = a / b;
            q  = DW'(qq);
            r  = WIDTH'(a % b);
            ov = (qq > longint'(2**(DW-1) - 1));
        end
    endfunction

    // Expected outputs: an accepted op reports LAT edges later; start is
    // ignored while an op is outstanding; reset clears everything.
    logic            exp_busy, exp_done, exp_dz, exp_ovf;
    logic [DW-1:0]   exp_q, pend_q, mq;
    logic [WIDTH-1:0] exp_r, pend_r, mr;
    logic            pend_dz, pend_ovf, mdz, movf;
    int              remaining;

    always @(posedge clk) begin
        if (rst) begin
            exp_busy  <= 1'b0;
            exp_done  <= 1'b0;
            exp_q     <= '0;
            exp_r     <= '0;
            exp_dz    <= 1'b0;
            exp_ovf   <= 1'b0;
            remaining <= 0;
        end else if (remaining != 0) begin
            remaining <= remaining - 1;
            if (remaining == 1) begin
                exp_done <= 1'b1;
                exp_busy <= 1'b0;
                exp_q    <= pend_q;
                exp_r    <= pend_r;
                exp_dz   <= pend_dz;
                exp_ovf  <= pend_ovf;
            end else begin
                exp_done <= 1'b0;
            end
        end else begin
            exp_done <= 1'b0;
            if (bus.start) begin
                model(bus.dividend, bus.divisor, mq, mr, mdz, movf);
                pend_q    <= mq;
                pend_r    <= mr;
                pend_dz   <= mdz;
                pend_ovf  <= movf;
                remaining <= LAT;
                exp_busy  <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy",      32'(bus.busy),      32'(exp_busy));
            check("done",      32'(bus.done),      32'(exp_done));
            check("quotient",  32'(bus.quotient),  32'(exp_q));
            check("remainder", 32'(bus.remainder), 32'(exp_r));
            check("div_zero",  32'(bus.div_zero),  32'(exp_dz));
            check("ovf",       32'(bus.ovf),       32'(exp_ovf));
        end
    end

    // Issue one op, wait for done (bounded) and check latency and literal results.
    task automatic do_op(input string name, input int dd, input int ds,
                         input int eq, input int er, input logic edz, input logic eov);
        int n;
        logic [DW-1:0]    eq_v;
        logic [WIDTH-1:0] er_v;
        eq_v = DW'(eq);
        er_v = WIDTH'(er);
        bus.start    = 1'b1;
        bus.dividend = DW'(dd);
        bus.divisor  = WIDTH'(ds);
        @(posedge clk); #1;
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, 32'(n), 32'(LAT));
        check({name, " q"},  32'(bus.quotient),  32'(eq_v));
        check({name, " r"},  32'(bus.remainder), 32'(er_v));
        check({name, " dz"}, 32'(bus.div_zero),  32'(edz));
        check({name, " ovf"}, 32'(bus.ovf),      32'(eov));
    endtask

    task automatic rand_ops(output logic [DW-1:0] dd, output logic [WIDTH-1:0] ds);
        case ($urandom_range(0, 7))
            0: dd = {1'b1, {(DW-1){1'b0}}};
            1: dd = {1'b0, {(DW-1){1'b1}}};
            2: dd = '1;
            3: dd = '0;
            default: dd = DW'($urandom);
        endcase
        case ($urandom_range(0, 9))
            0: ds = '0;
            1: ds = '1;
            2: ds = {1'b1, {(WIDTH-1){1'b0}}};
            3: ds = {1'b0, {(WIDTH-1){1'b1}}};
            4: ds = WIDTH'(1);
            default: ds = WIDTH'($urandom);
        endcase
    endtask

    initial begin
        int n, dones;
        logic [DW-1:0]    rdd;
        logic [WIDTH-1:0] rds;

        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;

        // Pin the reference model against hand-computed values.
        model(16'd1000, 8'd7, mq, mr, mdz, movf);
        check("model 1000/7 q", 32'(mq), 32'd142);
        check("model 1000/7 r", 32'(mr), 32'd6);
        model(DW'(-1000), WIDTH'(-7), mq, mr, mdz, movf);
        check("model -1000/-7 q", 32'(mq), 32'd142);
        check("model -1000/-7 r", 32'(mr), 32'hFA);
        model(16'd5, 8'd0, mq, mr, mdz, movf);
        check("model 5/0 q", 32'(mq), 32'hFFFF);
        check("model 5/0 dz", 32'(mdz), 32'd1);
        model(16'h8000, 8'hFF, mq, mr, mdz, movf);
        check("model min/-1 q", 32'(mq), 32'h8000);
        check("model min/-1 ovf", 32'(movf), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cmp_en = 1'b1;
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset q",    32'(bus.quotient), 32'd0);

        do_op("1000/7",     1000,   7,    142,  6,   1'b0, 1'b0);
        do_op("-1000/7",   -1000,   7,   -142, -6,   1'b0, 1'b0);
        do_op("1000/-7",    1000,  -7,   -142,  6,   1'b0, 1'b0);
        do_op("-1000/-7",  -1000,  -7,    142, -6,   1'b0, 1'b0);
        do_op("127/-128",   127,  -128,    0,  127,  1'b0, 1'b0);
        do_op("-32768/-128", -32768, -128, 256, 0,   1'b0, 1'b0);
        do_op("5/0",          5,    0,     -1,  5,   1'b1, 1'b0);
        do_op("-32768/-1", -32768,  -1, -32768, 0,   1'b0, 1'b1);
        do_op("20/3",        20,    3,      6,  2,   1'b0, 1'b0);

        // Start held high; operands change mid-op and must be ignored.
        bus.start    = 1'b1;
        bus.dividend = 16'd100;
        bus.divisor  = 8'd9;
        @(posedge clk); #1;
        repeat (4) begin @(posedge clk); #1; end
        bus.dividend = 16'd50;
        bus.divisor  = 8'd5;
        n = 0;
        while (!bus.done && n < 40) begin @(posedge clk); #1; n++; end
        check("hs first q", 32'(bus.quotient), 32'd11);
        check("hs first r", 32'(bus.remainder), 32'd1);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("hs second accepted", 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 40) begin @(posedge clk); #1; n++; end
        check("hs second latency", 32'(n), 32'(LAT));
        check("hs second q", 32'(bus.quotient), 32'd10);
        check("hs second r", 32'(bus.remainder), 32'd0);
        dones = 0;
        repeat (20) begin @(posedge clk); #1; if (bus.done) dones++; end
        check("hs extra done", 32'(dones), 32'd0);

        // Reset in the middle of an op: no done, everything cleared.
        bus.start    = 1'b1;
        bus.dividend = 16'd1000;
        bus.divisor  = 8'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort q",    32'(bus.quotient), 32'd0);
        check("abort r",    32'(bus.remainder), 32'd0);
        dones = 0;
        repeat (25) begin @(posedge clk); #1; if (bus.done) dones++; end
        check("abort no done", 32'(dones), 32'd0);
        do_op("9/4", 9, 4, 2, 1, 1'b0, 1'b0);

        // Randomized traffic, including start while busy and rare resets.
        repeat (3000) begin
            rand_ops(rdd, rds);
            bus.start    = ($urandom_range(0, 3) == 0);
            bus.dividend = rdd;
            bus.divisor  = rds;
            rst          = ($urandom_range(0, 599) == 0);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        rst = 1'b0;
        repeat (LAT + 3) begin @(posedge clk); #1; end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
